// File: rtl/input_conditioner.sv
// Key/switch front end: synchronizes raw inputs, debounces the key and latches the switch word on each accepted press.
// state        | meaning
// IDLE         | key released and stable
// PRESS_WAIT   | key seen pressed, counting stable cycles
// HELD         | press accepted, key still down
// RELEASE_WAIT | key seen released, counting stable cycles
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       trigger_raw,
   input  logic [9:0] sw_raw,
   input  logic       in_ack,
   output logic       trigger,
   output logic [9:0] in,
   output logic       in_valid,
   output logic       overrun,
   output logic       key_level
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             key_s1;
   logic             key_s2;
   logic [9:0]       sw_s1;
   logic [9:0]       sw_s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             press_event;

   always_ff @(posedge clock) begin
      if (reset) begin
         key_s1 <= 1'b0;
         key_s2 <= 1'b0;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= trigger_raw;
         key_s2 <= key_s1;
         sw_s1  <= sw_raw;
         sw_s2  <= sw_s1;
      end
   end

   // The press is accepted on the cycle the last stable count is confirmed.
   assign press_event = (state == PRESS_WAIT) && key_s2 && (cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         key_level <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (key_s2) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!key_s2) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state     <= HELD;
                  key_level <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (!key_s2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (key_s2) begin
                  state <= HELD;
               end else if (cnt == CNT_LAST) begin
                  state     <= IDLE;
                  key_level <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               key_level <= 1'b0;
            end
         endcase
      end
   end

   // An ack in the event cycle frees the slot before the new press claims it.
   always_ff @(posedge clock) begin
      if (reset) begin
         trigger  <= 1'b0;
         in       <= '0;
         in_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         trigger <= 1'b0;
         if (press_event && (!in_valid || in_ack)) begin
            trigger  <= 1'b1;
            in       <= sw_s2;
            in_valid <= 1'b1;
         end else begin
            if (in_ack) begin
               in_valid <= 1'b0;
            end
            if (press_event) begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed vector table, corner-case sequences and
// randomized key/switch traffic checked against a run-length debounce model.
module tb_input_conditioner;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       trigger_raw;
   logic [9:0] sw_raw;
   logic       in_ack;
   logic       trigger;
   logic [9:0] in;
   logic       in_valid;
   logic       overrun;
   logic       key_level;

   always #5 clock = ~clock;

   input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
      .clock(clock), .reset(reset), .trigger_raw(trigger_raw), .sw_raw(sw_raw),
      .in_ack(in_ack), .trigger(trigger), .in(in), .in_valid(in_valid),
      .overrun(overrun), .key_level(key_level)
   );

   int total = 0;
   int bad   = 0;
   int trig_count;
   int first_idx;

   // Model: the accepted level flips once the synchronized key has differed
   // from it on D+1 consecutive clock edges.
   logic       m_s1, m_s2;
   logic [9:0] m_sw1, m_sw2;
   logic       m_lvl, m_trig, m_valid, m_ovr;
   logic [9:0] m_in;
   int         m_run;

   task automatic model_step();
      logic ev;
      ev = 1'b0;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_sw1 = 0; m_sw2 = 0;
         m_lvl = 0; m_run = 0; m_trig = 0; m_in = 0; m_valid = 0; m_ovr = 0;
      end else begin
         if (m_s2 != m_lvl) begin
            m_run = m_run + 1;
            if (m_run == D + 1) begin
               m_lvl = ~m_lvl;
               m_run = 0;
               ev = m_lvl;
            end
         end else begin
            m_run = 0;
         end
         m_trig = 1'b0;
         if (in_ack) m_valid = 1'b0;
         if (ev) begin
            if (!m_valid) begin
               m_trig = 1'b1; m_in = m_sw2; m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end
         m_s2 = m_s1; m_s1 = trigger_raw;
         m_sw2 = m_sw1; m_sw1 = sw_raw;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [13:0] outs();
      return {trigger, in, in_valid, overrun, key_level};
   endfunction

   task automatic cycle(input logic r, input logic raw, input logic [9:0] sw, input logic ack);
      reset = r; trigger_raw = raw; sw_raw = sw; in_ack = ack;
      @(posedge clock);
      model_step();
      #1;
      if (trigger) trig_count++;
      chk("model", {18'd0, outs()}, {18'd0, m_trig, m_in, m_valid, m_ovr, m_lvl});
   endtask

   task automatic run(input int n, input logic r, input logic raw, input logic [9:0] sw);
      for (int i = 0; i < n; i++) begin
         cycle(r, raw, sw, 1'b0);
         if (trigger && first_idx < 0) first_idx = i;
      end
   endtask

   typedef struct {
      logic       rst;
      logic       raw;
      logic [9:0] sw;
      logic       ack;
      int         n;
      logic       trig;
      logic [9:0] in_e;
      logic       valid;
      logic       ovr;
      logic       lvl;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic lv;
      int   len;
      logic lvl_drop;

      //                rst  raw  sw       ack  n  trig in_e     v  o  lvl
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 2, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 10'h2A5, 1'b0, 6, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 10'h2A5, 1'b0, 1, 1'b1, 10'h2A5, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 10'h2A5, 1'b0, 1, 1'b0, 10'h2A5, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 10'h2A5, 1'b1, 1, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 10'h2A5, 1'b0, 6, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 10'h2A5, 1'b0, 1, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 10'h2A5, 1'b1, 1, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 10'h155, 1'b0, 3, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 10'h155, 1'b0, 4, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 10'h155, 1'b0, 8, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h155, 1'b0, 1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 10'h155, 1'b0, 2, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0});

      trig_count = 0;
      first_idx  = -1;
      foreach (tbl[k]) begin
         for (int i = 0; i < tbl[k].n; i++) cycle(tbl[k].rst, tbl[k].raw, tbl[k].sw, tbl[k].ack);
         chk($sformatf("vec%0d", k), {18'd0, outs()},
             {18'd0, tbl[k].trig, tbl[k].in_e, tbl[k].valid, tbl[k].ovr, tbl[k].lvl});
      end

      // Bounce: toggle every 2 cycles for 12 cycles, then hold pressed.
      run(2, 1'b1, 1'b0, 10'h0F0);
      trig_count = 0;
      for (int i = 0; i < 12; i++) cycle(1'b0, ((i / 2) % 2) == 0, 10'h0F0, 1'b0);
      chk("bounce_quiet", trig_count, 0);
      first_idx = -1;
      run(20, 1'b0, 1'b1, 10'h0F0);
      chk("bounce_pulses", trig_count, 1);
      chk("bounce_when", first_idx, 6);
      chk("bounce_in", in, 10'h0F0);

      // Overrun: second press while the first word is unconsumed.
      run(2, 1'b1, 1'b0, 10'h000);
      trig_count = 0;
      run(12, 1'b0, 1'b1, 10'h001);
      run(12, 1'b0, 1'b0, 10'h001);
      run(12, 1'b0, 1'b1, 10'h3FF);
      chk("ovr_in", in, 10'h001);
      chk("ovr_flag", overrun, 1);
      chk("ovr_pulses", trig_count, 1);
      chk("ovr_valid", in_valid, 1);
      cycle(1'b0, 1'b1, 10'h3FF, 1'b1);
      chk("ovr_ack", in_valid, 0);
      chk("ovr_sticky", overrun, 1);

      // Ack coinciding with the press event.
      run(2, 1'b1, 1'b0, 10'h000);
      run(12, 1'b0, 1'b1, 10'h0AA);
      run(12, 1'b0, 1'b0, 10'h0AA);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 10'h155, 1'b0);
      chk("sim_pre_valid", in_valid, 1);
      chk("sim_pre_trig", trigger, 0);
      cycle(1'b0, 1'b1, 10'h155, 1'b1);
      chk("sim_trig", trigger, 1);
      chk("sim_in", in, 10'h155);
      chk("sim_valid", in_valid, 1);
      chk("sim_ovr", overrun, 0);

      // Reset in HELD with the key still down.
      run(2, 1'b1, 1'b0, 10'h000);
      run(12, 1'b0, 1'b1, 10'h123);
      chk("rst_held_lvl", key_level, 1);
      run(2, 1'b1, 1'b1, 10'h123);
      chk("rst_outputs", {18'd0, outs()}, 32'd0);
      trig_count = 0;
      first_idx  = -1;
      run(20, 1'b0, 1'b1, 10'h321);
      chk("rst_pulses", trig_count, 1);
      chk("rst_when", first_idx, 6);
      chk("rst_in", in, 10'h321);

      // Long hold.
      run(2, 1'b1, 1'b0, 10'h000);
      trig_count = 0;
      lvl_drop = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         cycle(1'b0, 1'b1, 10'h00F, 1'b0);
         if (trig_count > 0 && !key_level) lvl_drop = 1'b1;
      end
      chk("long_pulses", trig_count, 1);
      chk("long_level", lvl_drop, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; ) begin
         len = $urandom_range(1, 9);
         lv  = 1'($urandom_range(0, 1));
         for (int j = 0; j < len && i < 3000; j++) begin
            cycle($urandom_range(0, 299) == 0, lv, 10'($urandom), $urandom_range(0, 7) == 0);
            i++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
